ddr_port_arbiter: RTL and testbench

//  Shares the single DDR burst interface among N requesters: instruction cache, data cache and the context store path.
//  Per-requester read/write burst requests are arbitrated round-robin, and one request is forwarded to the DDR controller.
//  The grant is held for the whole burst. Read beats and write-data pulls are routed to the owner, and a done pulse is returned.

---
 rtl/ddr_port_arbiter_if.sv | 45 ++++
 rtl/ddr_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_ddr_port_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_port_arbiter_if.sv
// Bundles the requester-side and DDR-controller-side signals of the DDR port arbiter.
// The slave modport is the arbiter's view; master is the combined requester/controller view.
interface ddr_port_arbiter_if #(
    parameter int N_REQ          = 3,
    parameter int DATA_WIDTH     = 16,
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int LEN_WIDTH      = 10
);
    logic [N_REQ-1:0]                     req_rd;
    logic [N_REQ-1:0]                     req_wr;
    logic [N_REQ-1:0][DDR_ADDR_WIDTH-1:0] req_addr;
    logic [N_REQ-1:0][LEN_WIDTH-1:0]      req_len;
    logic [N_REQ-1:0][DATA_WIDTH-1:0]     req_wdata;
    logic [N_REQ-1:0]                     grant;
    logic [DATA_WIDTH-1:0]                rdata;
    logic [N_REQ-1:0]                     rdata_valid;
    logic [N_REQ-1:0]                     wdata_req;
    logic [N_REQ-1:0]                     done;
    logic                                 rd_burst_req;
    logic                                 wr_burst_req;
    logic [DDR_ADDR_WIDTH-1:0]            burst_addr;
    logic [LEN_WIDTH-1:0]                 burst_len;
    logic [DATA_WIDTH-1:0]                rd_burst_data;
    logic                                 rd_burst_data_valid;
    logic                                 wr_burst_data_req;
    logic [DATA_WIDTH-1:0]                wr_burst_data;
    logic                                 rd_burst_finish;
    logic                                 wr_burst_finish;

    modport slave (
        input  req_rd, req_wr, req_addr, req_len, req_wdata,
        input  rd_burst_data, rd_burst_data_valid, wr_burst_data_req,
        input  rd_burst_finish, wr_burst_finish,
        output grant, rdata, rdata_valid, wdata_req, done,
        output rd_burst_req, wr_burst_req, burst_addr, burst_len, wr_burst_data
    );

    modport master (
        output req_rd, req_wr, req_addr, req_len, req_wdata,
        output rd_burst_data, rd_burst_data_valid, wr_burst_data_req,
        output rd_burst_finish, wr_burst_finish,
        input  grant, rdata, rdata_valid, wdata_req, done,
        input  rd_burst_req, wr_burst_req, burst_addr, burst_len, wr_burst_data
    );
endinterface

// File: rtl/ddr_port_arbiter.sv
// Round-robin arbiter sharing one DDR burst port among N_REQ requesters.
// The grant is held for the whole burst; beats and write pulls are steered to the owner.
module ddr_port_arbiter #(
    parameter int N_REQ          = 3,
    parameter int DATA_WIDTH     = 16,
    parameter int DDR_ADDR_WIDTH = 28,
    parameter int LEN_WIDTH      = 10
) (
    input  logic             clk,
    input  logic             rst,
    ddr_port_arbiter_if.slave bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_RD, S_WR, S_DONE} state_e;

    state_e                    state_q, state_d;
    logic [N_REQ-1:0]          grant_q, grant_d;
    logic [IDX_W-1:0]          owner_q, owner_d;
    logic [IDX_W-1:0]          ptr_q, ptr_d;
    logic [DDR_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]      len_q, len_d;
    logic [LEN_WIDTH-1:0]      beat_q, beat_d;
    logic                      wr_q, wr_d;
    logic                      started_q, started_d;

    logic [N_REQ-1:0]          req_any;
    logic                      found;
    logic [IDX_W-1:0]          sel;
    logic [IDX_W:0]            cand;
    logic                      in_range, rd_ok, wr_ok;
    logic [DATA_WIDTH-1:0]     wdata_mux;

    assign req_any = bus.req_rd | bus.req_wr;

    // First requester at or after the rr pointer, wrapping modulo N_REQ.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_REQ))
                cand = cand - (IDX_W+1)'(N_REQ);
            if (!found && req_any[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                sel   = cand[IDX_W-1:0];
            end
        end
    end

    // Beats past burst_len are dropped rather than forwarded.
    assign in_range = beat_q < len_q;
    assign rd_ok    = (state_q == S_RD) && bus.rd_burst_data_valid && in_range;
    assign wr_ok    = (state_q == S_WR) && bus.wr_burst_data_req && in_range;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        wr_d      = wr_q;
        started_d = started_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d      = S_ARB;
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                    owner_d      = sel;
                    addr_d       = bus.req_addr[sel];
                    len_d        = bus.req_len[sel];
                    wr_d         = bus.req_wr[sel];
                end
            end
            S_ARB: begin
                beat_d    = '0;
                started_d = 1'b0;
                if (len_q == '0)  state_d = S_DONE;
                else if (wr_q)    state_d = S_WR;
                else              state_d = S_RD;
            end
            S_RD: begin
                if (rd_ok)                   beat_d    = beat_q + LEN_WIDTH'(1);
                if (bus.rd_burst_data_valid) started_d = 1'b1;
                if (bus.rd_burst_finish)     state_d   = S_DONE;
            end
            S_WR: begin
                if (wr_ok)                 beat_d    = beat_q + LEN_WIDTH'(1);
                if (bus.wr_burst_data_req) started_d = 1'b1;
                if (bus.wr_burst_finish)   state_d   = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = '0;
                beat_d  = '0;
                ptr_d   = (owner_q == IDX_W'(N_REQ-1)) ? '0 : owner_q + IDX_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            wr_q      <= 1'b0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            wr_q      <= wr_d;
            started_q <= started_d;
        end
    end

    // AND-OR mux so an idle (all-zero) grant drives zero write data.
    always_comb begin
        wdata_mux = '0;
        for (int i = 0; i < N_REQ; i++)
            if (grant_q[i]) wdata_mux = wdata_mux | bus.req_wdata[i];
    end

    assign bus.grant         = grant_q;
    assign bus.burst_addr    = addr_q;
    assign bus.burst_len     = len_q;
    assign bus.rd_burst_req  = (state_q == S_RD) && !started_q;
    assign bus.wr_burst_req  = (state_q == S_WR) && !started_q;
    assign bus.rdata         = rd_ok ? bus.rd_burst_data : '0;
    assign bus.rdata_valid   = rd_ok ? grant_q : '0;
    assign bus.wdata_req     = wr_ok ? grant_q : '0;
    assign bus.done          = (state_q == S_DONE) ? grant_q : '0;
    assign bus.wr_burst_data = wdata_mux;
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed bench for ddr_port_arbiter: single read, round robin, write,
// rd+wr priority, zero-length burst and mid-burst reset.
module tb_ddr_port_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   nchk = 0;
    int   nerr = 0;

    ddr_port_arbiter_if #(.N_REQ(3), .DATA_WIDTH(16), .DDR_ADDR_WIDTH(28), .LEN_WIDTH(10)) bus ();

    ddr_port_arbiter #(.N_REQ(3), .DATA_WIDTH(16), .DDR_ADDR_WIDTH(28), .LEN_WIDTH(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One len=1 read burst for a requester already holding req_rd, starting in IDLE.
    task automatic rr_round(input int own, input logic [27:0] exp_addr);
        tick();
        chk("rr_grant", 64'(bus.grant), 64'(3'b001 << own));
        tick();
        chk("rr_rdreq", 64'(bus.rd_burst_req), 64'(1));
        chk("rr_addr", 64'(bus.burst_addr), 64'(exp_addr));
        bus.rd_burst_data = 16'h5000 + 16'(own);
        bus.rd_burst_data_valid = 1'b1;
        #1;
        chk("rr_rvalid", 64'(bus.rdata_valid), 64'(3'b001 << own));
        tick();
        bus.rd_burst_data_valid = 1'b0;
        bus.rd_burst_finish = 1'b1;
        tick();
        bus.rd_burst_finish = 1'b0;
        #1;
        chk("rr_done", 64'(bus.done), 64'(3'b001 << own));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.req_rd = '0;
        bus.req_wr = '0;
        bus.req_addr = '0;
        bus.req_len = '0;
        bus.req_wdata = '0;
        bus.rd_burst_data = '0;
        bus.rd_burst_data_valid = 1'b0;
        bus.wr_burst_data_req = 1'b0;
        bus.rd_burst_finish = 1'b0;
        bus.wr_burst_finish = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", 64'(bus.grant), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_rdreq", 64'(bus.rd_burst_req), 64'(0));
        chk("rst_wrreq", 64'(bus.wr_burst_req), 64'(0));
        chk("rst_addr", 64'(bus.burst_addr), 64'(0));
        chk("rst_len", 64'(bus.burst_len), 64'(0));
        rst = 1'b0;

        // Single read on requester 1, 4 beats plus one stray beat
        bus.req_rd = 3'b010;
        bus.req_addr[1] = 28'h100;
        bus.req_len[1] = 10'd4;
        #1;
        chk("t1_idle_rdreq", 64'(bus.rd_burst_req), 64'(0));
        tick();
        chk("t1_arb_grant", 64'(bus.grant), 64'(3'b010));
        chk("t1_arb_rdreq", 64'(bus.rd_burst_req), 64'(0));
        tick();
        chk("t1_rdreq", 64'(bus.rd_burst_req), 64'(1));
        chk("t1_addr", 64'(bus.burst_addr), 64'(28'h100));
        chk("t1_len", 64'(bus.burst_len), 64'(4));
        for (int i = 0; i < 4; i++) begin
            bus.rd_burst_data = 16'h00A0 + 16'(i);
            bus.rd_burst_data_valid = 1'b1;
            #1;
            chk("t1_rvalid", 64'(bus.rdata_valid), 64'(3'b010));
            chk("t1_rdata", 64'(bus.rdata), 64'(16'h00A0 + 16'(i)));
            tick();
        end
        bus.rd_burst_data = 16'hDEAD;
        #1;
        chk("t1_extra_rvalid", 64'(bus.rdata_valid), 64'(0));
        chk("t1_extra_rdata", 64'(bus.rdata), 64'(0));
        chk("t1_rdreq_low", 64'(bus.rd_burst_req), 64'(0));
        tick();
        bus.rd_burst_data_valid = 1'b0;
        bus.rd_burst_finish = 1'b1;
        tick();
        bus.rd_burst_finish = 1'b0;
        #1;
        chk("t1_done", 64'(bus.done), 64'(3'b010));
        chk("t1_done_grant", 64'(bus.grant), 64'(3'b010));
        bus.req_rd = 3'b000;
        tick();
        chk("t1_idle_grant", 64'(bus.grant), 64'(0));
        chk("t1_idle_done", 64'(bus.done), 64'(0));

        // Round robin from a freshly reset pointer
        rst = 1'b1;
        #1;
        rst = 1'b0;
        bus.req_addr[0] = 28'h200;
        bus.req_addr[1] = 28'h300;
        bus.req_addr[2] = 28'h400;
        bus.req_len[0] = 10'd1;
        bus.req_len[1] = 10'd1;
        bus.req_len[2] = 10'd1;
        bus.req_rd = 3'b111;
        rr_round(0, 28'h200);
        rr_round(1, 28'h300);
        rr_round(2, 28'h400);
        rr_round(0, 28'h200);
        bus.req_rd = 3'b000;

        // Write burst on requester 2 with one stray pull
        bus.req_wr = 3'b100;
        bus.req_len[2] = 10'd3;
        bus.req_addr[2] = 28'h777;
        tick();
        chk("t3_grant", 64'(bus.grant), 64'(3'b100));
        tick();
        chk("t3_wrreq", 64'(bus.wr_burst_req), 64'(1));
        chk("t3_rdreq", 64'(bus.rd_burst_req), 64'(0));
        chk("t3_addr", 64'(bus.burst_addr), 64'(28'h777));
        for (int i = 0; i < 3; i++) begin
            bus.req_wdata[2] = 16'hB000 + 16'(i);
            bus.wr_burst_data_req = 1'b1;
            #1;
            chk("t3_wdreq", 64'(bus.wdata_req), 64'(3'b100));
            chk("t3_wdata", 64'(bus.wr_burst_data), 64'(16'hB000 + 16'(i)));
            tick();
        end
        #1;
        chk("t3_extra_wdreq", 64'(bus.wdata_req), 64'(0));
        chk("t3_wrreq_low", 64'(bus.wr_burst_req), 64'(0));
        tick();
        bus.wr_burst_data_req = 1'b0;
        bus.wr_burst_finish = 1'b1;
        tick();
        bus.wr_burst_finish = 1'b0;
        #1;
        chk("t3_done", 64'(bus.done), 64'(3'b100));
        bus.req_wr = 3'b000;
        tick();
        chk("t3_idle_grant", 64'(bus.grant), 64'(0));

        // Requester 1 with rd and wr: write first, read next round
        bus.req_rd = 3'b010;
        bus.req_wr = 3'b010;
        bus.req_len[1] = 10'd2;
        tick();
        chk("t4_grant_w", 64'(bus.grant), 64'(3'b010));
        tick();
        chk("t4_wrreq", 64'(bus.wr_burst_req), 64'(1));
        chk("t4_rdreq0", 64'(bus.rd_burst_req), 64'(0));
        for (int i = 0; i < 2; i++) begin
            bus.req_wdata[1] = 16'hC000 + 16'(i);
            bus.wr_burst_data_req = 1'b1;
            #1;
            chk("t4_wdata", 64'(bus.wr_burst_data), 64'(16'hC000 + 16'(i)));
            tick();
        end
        bus.wr_burst_data_req = 1'b0;
        bus.wr_burst_finish = 1'b1;
        tick();
        bus.wr_burst_finish = 1'b0;
        #1;
        chk("t4_done_w", 64'(bus.done), 64'(3'b010));
        bus.req_wr = 3'b000;
        tick();
        tick();
        chk("t4_grant_r", 64'(bus.grant), 64'(3'b010));
        tick();
        chk("t4_rdreq", 64'(bus.rd_burst_req), 64'(1));
        chk("t4_wrreq0", 64'(bus.wr_burst_req), 64'(0));
        bus.rd_burst_data = 16'h0042;
        bus.rd_burst_data_valid = 1'b1;
        #1;
        chk("t4_rvalid", 64'(bus.rdata_valid), 64'(3'b010));
        tick();
        bus.rd_burst_data_valid = 1'b0;
        bus.rd_burst_finish = 1'b1;
        tick();
        bus.rd_burst_finish = 1'b0;
        #1;
        chk("t4_done_r", 64'(bus.done), 64'(3'b010));
        bus.req_rd = 3'b000;
        tick();

        // Zero-length request on requester 0
        bus.req_rd = 3'b001;
        bus.req_len[0] = 10'd0;
        tick();
        chk("t5_grant", 64'(bus.grant), 64'(3'b001));
        tick();
        chk("t5_done", 64'(bus.done), 64'(3'b001));
        chk("t5_rdreq", 64'(bus.rd_burst_req), 64'(0));
        chk("t5_wrreq", 64'(bus.wr_burst_req), 64'(0));
        bus.req_rd = 3'b000;
        tick();
        chk("t5_done_clr", 64'(bus.done), 64'(0));

        // Reset after 2 of 4 beats; pointer must restart at 0
        bus.req_rd = 3'b010;
        bus.req_len[1] = 10'd4;
        bus.req_addr[1] = 28'h100;
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            bus.rd_burst_data = 16'h0E00 + 16'(i);
            bus.rd_burst_data_valid = 1'b1;
            tick();
        end
        bus.rd_burst_data = 16'h1234;
        rst = 1'b1;
        #1;
        chk("t6_rvalid", 64'(bus.rdata_valid), 64'(0));
        chk("t6_rdata", 64'(bus.rdata), 64'(0));
        chk("t6_grant", 64'(bus.grant), 64'(0));
        chk("t6_rdreq", 64'(bus.rd_burst_req), 64'(0));
        chk("t6_done", 64'(bus.done), 64'(0));
        chk("t6_addr", 64'(bus.burst_addr), 64'(0));
        bus.rd_burst_data_valid = 1'b0;
        bus.req_rd = 3'b000;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_done_after", 64'(bus.done), 64'(0));
        bus.req_rd = 3'b011;
        bus.req_len[0] = 10'd1;
        bus.req_len[1] = 10'd1;
        tick();
        chk("t6_grant_ptr0", 64'(bus.grant), 64'(3'b001));
        tick();
        bus.rd_burst_data_valid = 1'b1;
        tick();
        bus.rd_burst_data_valid = 1'b0;
        bus.rd_burst_finish = 1'b1;
        tick();
        bus.rd_burst_finish = 1'b0;
        #1;
        chk("t6_done0", 64'(bus.done), 64'(3'b001));
        bus.req_rd = 3'b000;
        tick();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
